// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-register widths, bubble values and stage/occupancy enums.
package pipe_pkg;
   localparam int IFID_CTRL_W  = 0;
   localparam int IDEX_CTRL_W  = 16;
   localparam int EXMEM_CTRL_W = 11;
   localparam int MEMWB_CTRL_W = 5;
   localparam logic [IDEX_CTRL_W-1:0]  BUBBLE_IDEX_CTRL  = '0;
   localparam logic [EXMEM_CTRL_W-1:0] BUBBLE_EXMEM_CTRL = '0;
   localparam logic [MEMWB_CTRL_W-1:0] BUBBLE_MEMWB_CTRL = '0;
   typedef enum logic [2:0] {IF, ID, EX, MEM, WB} stage_e;
   // Encoding doubles as the entry count presented on occupancy.
   typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} occ_e;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: one-entry holding register with valid flag; reset clears, write wins over read.
module pipe_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr,
   input  logic         rd,
   input  logic [W-1:0] wr_data,
   output logic         valid,
   output logic [W-1:0] rd_data
);
   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   always_comb begin
      valid_d = reset ? 1'b0 : wr ? 1'b1 : rd ? 1'b0 : valid_q;
      data_d  = wr ? wr_data : data_q;
   end
   always_ff @(posedge clk) begin
      valid_q <= valid_d;
      data_q  <= data_d;
   end
   assign valid   = valid_q;
   assign rd_data = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush-to-bubble and stall.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                CTRL_W      = 11,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              stall,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);
   occ_e              state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              in_fire, out_fire;
   assign out_valid = state_q != ST_EMPTY;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready & !stall;
`ifdef PIPE_STAGE_SKID_EN
   logic                     skid_valid, skid_wr, skid_rd;
   logic [DATA_W+CTRL_W-1:0] skid_data;
   assign in_ready = !reset & !flush & !skid_valid;
   assign skid_wr  = in_fire & out_valid & !out_fire;
   assign skid_rd  = out_fire & skid_valid;
   pipe_skid_buf #(.W(DATA_W + CTRL_W)) u_skid (
      .clk     (clk),
      .reset   (reset | flush),
      .wr      (skid_wr),
      .rd      (skid_rd),
      .wr_data ({in_data, in_ctrl}),
      .valid   (skid_valid),
      .rd_data (skid_data)
   );
`else
   assign in_ready = !reset & !flush & (!out_valid | (out_ready & !stall));
`endif
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
      // Skid holds the older entry, so it refills main before any new input.
      if (skid_valid) begin
         if (out_fire) begin
            {data_d, ctrl_d} = skid_data;
            state_d          = ST_ONE;
         end
      end else if (in_fire) begin
         if (!out_valid | out_fire) begin
            data_d = in_data;
            ctrl_d = in_ctrl;
         end
         state_d = (out_valid & !out_fire) ? ST_TWO : ST_ONE;
      end else if (out_fire) begin
         state_d = ST_EMPTY;
      end
`else
      if (in_fire) begin
         data_d  = in_data;
         ctrl_d  = in_ctrl;
         state_d = ST_ONE;
      end else if (out_fire) begin
         state_d = ST_EMPTY;
      end
`endif
      if (reset | flush) begin
         state_d = ST_EMPTY;
         data_d  = '0;
         ctrl_d  = BUBBLE_CTRL;
      end
   end
   always_ff @(posedge clk) begin
      state_q <= state_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
   end
   assign out_data  = data_q;
   assign out_ctrl  = ctrl_q;
   assign occupancy = state_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random stimulus checked against a queue model of the stage.
module tb_pipe_stage_reg;
`ifdef PIPE_STAGE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif
   localparam logic [10:0] BUB = 11'h4A5;
   typedef struct packed {
      logic [31:0] d;
      logic [10:0] c;
   } ent_t;
   logic        clk = 1'b0;
   logic        reset, flush, stall, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data, out_data;
   logic [10:0] in_ctrl, out_ctrl;
   logic [1:0]  occupancy;
   ent_t        q[$];
   ent_t        shown;
   logic        exp_rdy;
   bit          warm;
   int          vecs, errs;
   always #5 clk = ~clk;
   pipe_stage_reg #(.DATA_W(32), .CTRL_W(11), .BUBBLE_CTRL(BUB)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .stall     (stall),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .occupancy (occupancy)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic cyc(input logic r, input logic f, input logic s, input logic iv,
                      input logic [31:0] d, input logic [10:0] c, input logic ordy);
      bit fo, fi;
      @(negedge clk);
      reset = r; flush = f; stall = s; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
      #1;
      exp_rdy = !r && !f && (CAP == 2 ? q.size() < 2 : (q.size() == 0 || (ordy && !s)));
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (warm) begin
         chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
         chk("out_data", 64'(out_data), 64'(shown.d));
         chk("out_ctrl", 64'(out_ctrl), 64'(shown.c));
         chk("occupancy", 64'(occupancy), 64'(q.size()));
      end
      fo = q.size() > 0 && ordy && !s;
      fi = iv && exp_rdy;
      if (r || f) begin
         q.delete();
         shown = ent_t'{32'h0, BUB};
         warm  = 1'b1;
      end else begin
         if (fo) void'(q.pop_front());
         if (fi) q.push_back(ent_t'{d, c});
         if (q.size() > 0) shown = q[0];
      end
   endtask
   initial begin
      vecs = 0; errs = 0; warm = 1'b0;
      shown = ent_t'{32'h0, BUB};
      // reset held two cycles with input offered
      cyc(1, 0, 0, 1, 32'hDEAD, 11'h1, 1);
      cyc(1, 0, 0, 1, 32'hBEEF, 11'h2, 1);
      // streaming 1..8
      for (int i = 1; i <= 8; i++) cyc(0, 0, 0, 1, 32'(i), 11'(i + 16), 1);
      cyc(0, 0, 0, 0, 32'h0, 11'h0, 1);
      cyc(0, 0, 0, 0, 32'h0, 11'h0, 1);
      // backpressure
      cyc(0, 0, 0, 1, 32'hA5, 11'h0A5, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 32'hA6, 11'h0A6, 0);
      cyc(0, 0, 0, 1, 32'hA6, 11'h0A6, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 32'h0, 11'h0, 1);
      // stall with out_ready high
      cyc(0, 0, 0, 1, 32'h51, 11'h051, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 32'h0, 11'h0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 32'h0, 11'h0, 1);
      // flush while full, with 0x77 offered
      cyc(0, 0, 0, 1, 32'h61, 11'h061, 0);
      cyc(0, 0, 0, 1, 32'h62, 11'h062, 0);
      cyc(0, 1, 0, 1, 32'h77, 11'h077, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 32'h77, 11'h077, 1);
      // reset mid-burst
      for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 1, 32'(i + 32'h100), 11'(i), 1);
      cyc(1, 0, 0, 1, 32'h105, 11'h5, 1);
      cyc(0, 0, 0, 1, 32'h200, 11'h200, 1);
      cyc(0, 0, 0, 0, 32'h0, 11'h0, 1);
      cyc(0, 0, 0, 0, 32'h0, 11'h0, 1);
      // random traffic
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0),
             $urandom, 11'($urandom), 1'($urandom_range(0, 3) != 0));
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
